// File: rtl/fsm_mode_pkg.sv
// -----------------------------------------------------------------------------
// fsm_mode_pkg
// Shared definitions for the mode scheduler:
//   - state_t   : controller state encoding (3 bits; values 5..7 are illegal)
//   - DEF_*     : default parameter values used by fsm_mode_sched
//   - onehot()  : index to one-hot vector, sized for the largest legal N_REQ
// -----------------------------------------------------------------------------
package fsm_mode_pkg;

    localparam int MAX_REQ      = 8;
    localparam int DEF_N_REQ    = 3;
    localparam int DEF_MODE_W   = 3;
    localparam int DEF_MODE_MAX = 3;
    localparam int DEF_MAX_OWN  = 16;
    localparam int DEF_COOL_CYC = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARB      = 3'd1,
        OWNED    = 3'd2,
        COOLDOWN = 3'd3,
        LOCKED   = 3'd4
    } state_t;

    // Callers truncate the result to their own requester count.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        logic [MAX_REQ-1:0] v;
        v = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/fsm_mode_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req starting at rr_ptr and wrapping
// around; the first set bit found wins.
// Ports:
//   req    in  N_REQ  request vector
//   rr_ptr in  IDX_W  index with highest priority this cycle
//   valid  out 1      at least one request set
//   idx    out IDX_W  winning requester index (0 when valid=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int               sum;
    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit to rr_ptr is
    // the last write and therefore the winner.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = 0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum  = int'(rr_ptr) + k;
            cand = IDX_W'((sum >= N_REQ) ? (sum - N_REQ) : sum);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fsm_mode_sched.sv
// -----------------------------------------------------------------------------
// fsm_mode_sched
// Arbitrates N_REQ requesters for ownership of a shared mode register. The
// winning requester's mode is applied and held while it owns the resource, a
// cooldown separates consecutive owners, and a latched lock freezes everything
// until reset.
// Ports:
//   clk       in  1             rising-edge clock
//   rst       in  1             asynchronous active-high reset
//   req       in  N_REQ         level-held ownership requests
//   req_mode  in  N_REQ*MODE_W  requested modes, slice i for requester i
//   rel       in  N_REQ         one-cycle release strobe from the owner
//                               (the name "release" is a reserved word)
//   lock      in  1             security lock request (latched)
//   gnt       out N_REQ         registered one-hot grant
//   mode_out  out MODE_W        registered applied mode
//   busy      out 1             high in ARB, OWNED, COOLDOWN, LOCKED
//   err       out 1             registered one-cycle error pulse
// -----------------------------------------------------------------------------
module fsm_mode_sched
    import fsm_mode_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MODE_W   = DEF_MODE_W,
    parameter int MODE_MAX = DEF_MODE_MAX,
    parameter int MAX_OWN  = DEF_MAX_OWN,
    parameter int COOL_CYC = DEF_COOL_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*MODE_W-1:0]   req_mode,
    input  logic [N_REQ-1:0]          rel,
    input  logic                      lock,
    output logic [N_REQ-1:0]          gnt,
    output logic [MODE_W-1:0]         mode_out,
    output logic                      busy,
    output logic                      err
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OWN_W  = $clog2(MAX_OWN + 1);
    localparam int COOL_W = $clog2(COOL_CYC + 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0]    own_cnt_q, own_cnt_d;
    logic [COOL_W-1:0]   cool_cnt_q, cool_cnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                err_q, err_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [MODE_W-1:0]   mode_arr [N_REQ];
    logic                owner_rel;
    logic                owner_drop;
    logic                timeout;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mode_slice
        assign mode_arr[gi] = req_mode[gi*MODE_W +: MODE_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        own_cnt_d  = own_cnt_q;
        cool_cnt_d = cool_cnt_q;
        gnt_d      = gnt_q;
        mode_d     = mode_q;
        err_d      = 1'b0;
        owner_rel  = rel[owner_q];
        owner_drop = ~req[owner_q];
        timeout    = (own_cnt_q == OWN_W'(MAX_OWN - 1));

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (lock)
                    state_d = LOCKED;
                else if (|req)
                    state_d = ARB;
            end

            ARB: begin
                gnt_d = '0;
                if (lock) begin
                    state_d = LOCKED;
                end else if (!pick_valid) begin
                    state_d = IDLE;
                end else if (int'(mode_arr[pick_idx]) > MODE_MAX) begin
                    // Reject the winner but advance past it so a stuck bad
                    // requester cannot starve the others.
                    err_d    = 1'b1;
                    rr_ptr_d = wrap_inc(pick_idx);
                    state_d  = IDLE;
                end else begin
                    owner_d   = pick_idx;
                    mode_d    = mode_arr[pick_idx];
                    gnt_d     = N_REQ'(onehot(32'(pick_idx)));
                    own_cnt_d = '0;
                    state_d   = OWNED;
                end
            end

            OWNED: begin
                own_cnt_d = own_cnt_q + OWN_W'(1);
                if (lock || owner_rel || owner_drop || timeout) begin
                    gnt_d      = '0;
                    cool_cnt_d = '0;
                    rr_ptr_d   = wrap_inc(owner_q);
                    state_d    = lock ? LOCKED : COOLDOWN;
                    // A voluntary exit in the same cycle as the timeout is
                    // not a watchdog event.
                    err_d      = timeout & ~owner_rel & ~owner_drop & ~lock;
                end
            end

            COOLDOWN: begin
                gnt_d      = '0;
                cool_cnt_d = cool_cnt_q + COOL_W'(1);
                if (lock)
                    state_d = LOCKED;
                else if (cool_cnt_q == COOL_W'(COOL_CYC - 1))
                    state_d = IDLE;
            end

            LOCKED: begin
                gnt_d = '0;
            end

            default: begin
                // Unreachable encodings recover to IDLE and flag it; the
                // applied mode is deliberately left untouched.
                state_d = IDLE;
                gnt_d   = '0;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            own_cnt_q  <= '0;
            cool_cnt_q <= '0;
            gnt_q      <= '0;
            mode_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            own_cnt_q  <= own_cnt_d;
            cool_cnt_q <= cool_cnt_d;
            gnt_q      <= gnt_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
        end
    end

    assign gnt      = gnt_q;
    assign mode_out = mode_q;
    assign err      = err_q;
    assign busy     = (state_q == ARB) || (state_q == OWNED) ||
                      (state_q == COOLDOWN) || (state_q == LOCKED);

endmodule

// File: tb/tb_fsm_mode_sched.sv
// -----------------------------------------------------------------------------
// tb_fsm_mode_sched
// Directed scenarios with literal expectations, plus a behavioural model of
// ownership (who owns, for how long, cooldown remaining, lock latched) that is
// compared against the DUT outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_fsm_mode_sched;

    localparam int N        = 3;
    localparam int MODE_MAX = 3;
    localparam int MAX_OWN  = 16;
    localparam int COOL     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [8:0] req_mode;
    logic [2:0] rel;
    logic       lock;
    logic [2:0] gnt;
    logic [2:0] mode_out;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    fsm_mode_sched dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_mode (req_mode),
        .rel      (rel),
        .lock     (lock),
        .gnt      (gnt),
        .mode_out (mode_out),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit locked;
        int owner;      // -1 when nobody owns the resource
        int age;        // cycles already spent by the current owner
        int cool_left;  // cooldown cycles still to run
        bit in_arb;     // a pick happens at the end of this cycle
        int ptr;        // first requester considered by the next pick
        int mode;
        bit err;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t reset_model();
        mdl_t r;
        r.locked = 0; r.owner = -1; r.age = 0; r.cool_left = 0;
        r.in_arb = 0; r.ptr = 0; r.mode = 0; r.err = 0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t c, logic [2:0] rq, logic [8:0] rm,
                                  logic [2:0] rl, logic lk);
        mdl_t n;
        bit   voluntary;
        int   w;
        int   md;
        n     = c;
        n.err = 0;
        if (c.locked) begin
            n = c;
            n.err = 0;
        end else if (c.owner >= 0) begin
            voluntary = rl[c.owner] || !rq[c.owner];
            if (lk) begin
                n.locked = 1; n.owner = -1; n.ptr = (c.owner + 1) % N;
            end else if (voluntary || c.age == MAX_OWN - 1) begin
                n.err = !voluntary;
                n.owner = -1; n.ptr = (c.owner + 1) % N; n.cool_left = COOL;
            end else begin
                n.age = c.age + 1;
            end
        end else if (c.cool_left > 0) begin
            if (lk) begin n.locked = 1; n.cool_left = 0; end
            else n.cool_left = c.cool_left - 1;
        end else if (c.in_arb) begin
            n.in_arb = 0;
            if (lk) n.locked = 1;
            else begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && rq[(c.ptr + k) % N]) w = (c.ptr + k) % N;
                if (w >= 0) begin
                    md = int'((rm >> (3 * w)) & 9'h7);
                    if (md > MODE_MAX) begin
                        n.err = 1; n.ptr = (w + 1) % N;
                    end else begin
                        n.owner = w; n.age = 0; n.mode = md;
                    end
                end
            end
        end else begin
            if (lk) n.locked = 1;
            else if (rq != 0) n.in_arb = 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= reset_model();
        else     m <= step(m, req, req_mode, rel, lock);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Directed checks also log one line each.
    task automatic dchk(input string name, input int act, input int exp);
        chk(name, act, exp);
        if (act == exp) $display("check %s: got %0d as expected", name, act);
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("cmp_gnt",  int'(gnt),  (m.owner >= 0) ? (1 << m.owner) : 0);
            chk("cmp_mode", int'(mode_out), m.mode);
            chk("cmp_busy", int'(busy),
                int'(m.locked || m.in_arb || m.owner >= 0 || m.cool_left > 0));
            chk("cmp_err",  int'(err), int'(m.err));
            chk("inv_onehot0", int'($onehot0(gnt)), 1);
            chk("inv_mode_legal", int'(mode_out <= 3'(MODE_MAX)), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (gnt == 3'b000 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (gnt == 3'b000) begin
            total++;
            bad++;
            $display("FAIL wait_gnt: no grant within 30 cycles, gnt=%0d required nonzero", gnt);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int cyc;
    int own;
    logic [2:0] rot_exp [4];

    initial begin
        rst = 1'b1; req = '0; rel = '0; req_mode = '0; lock = 1'b0;
        rot_exp[0] = 3'b001; rot_exp[1] = 3'b010;
        rot_exp[2] = 3'b100; rot_exp[3] = 3'b001;
        repeat (2) @(negedge clk);
        dchk("rst_gnt",  int'(gnt), 0);
        dchk("rst_mode", int'(mode_out), 0);
        dchk("rst_busy", int'(busy), 0);
        dchk("rst_err",  int'(err), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // S1: single requester, grant latency
        req_mode = {3'd0, 3'd2, 3'd0};
        req = 3'b010;
        @(negedge clk);
        dchk("s1_busy_c1", int'(busy), 1);
        dchk("s1_gnt_c1",  int'(gnt), 0);
        @(negedge clk);
        dchk("s1_gnt_c2",  int'(gnt), 3'b010);
        dchk("s1_mode_c2", int'(mode_out), 2);
        rel = 3'b010;
        @(negedge clk);
        rel = '0; req = '0;
        dchk("s1_gnt_rel",   int'(gnt), 0);
        dchk("s1_mode_kept", int'(mode_out), 2);
        repeat (3) @(negedge clk);

        // S2: rotation among three held requesters
        pulse_rst();
        req_mode = {3'd2, 3'd1, 3'd3};
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(cyc);
            // first grant: IDLE->ARB->OWNED; later: 2 cooldown + IDLE + ARB
            dchk("s2_gap", cyc, (g == 0) ? 2 : 4);
            dchk("s2_gnt", int'(gnt), int'(rot_exp[g]));
            repeat (2) @(negedge clk);
            rel = gnt;
            @(negedge clk);
            rel = '0;
            dchk("s2_drop", int'(gnt), 0);
        end
        wait_gnt(cyc);
        rst = 1'b1;
        #1;
        dchk("async_rst_gnt",  int'(gnt), 0);
        dchk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0; req = '0;
        @(negedge clk);

        // S3: illegal requested mode
        req_mode = {3'd0, 3'd0, 3'd5};
        req = 3'b001;
        @(negedge clk);
        @(negedge clk);
        dchk("s3_err",  int'(err), 1);
        dchk("s3_gnt",  int'(gnt), 0);
        dchk("s3_busy", int'(busy), 0);
        req_mode = {3'd2, 3'd3, 3'd1};
        req = 3'b111;
        wait_gnt(cyc);
        dchk("s3_lat",      cyc, 2);
        dchk("s3_ptr_gnt",  int'(gnt), 3'b010);
        dchk("s3_ptr_mode", int'(mode_out), 3);

        // S4: watchdog on requester 1
        own = 1;
        while (gnt != 3'b000 && own < 40) begin
            @(negedge clk);
            if (gnt != 3'b000) own++;
        end
        dchk("s4_own_cycles", own, 16);
        dchk("s4_err", int'(err), 1);
        @(negedge clk);
        dchk("s4_err_pulse", int'(err), 0);
        wait_gnt(cyc);
        dchk("s4_gap_rest", cyc, 3);
        dchk("s4_next_gnt", int'(gnt), 3'b100);
        dchk("s4_next_mode", int'(mode_out), 2);
        rel = 3'b100;
        @(negedge clk);
        rel = '0; req = '0;
        repeat (3) @(negedge clk);

        // S6: illegal state encoding recovery
        chk_en = 1'b0;
        force dut.state_q = fsm_mode_pkg::state_t'(3'b111);
        @(posedge clk);
        #1;
        dchk("s6_err",  int'(err), 1);
        dchk("s6_gnt",  int'(gnt), 0);
        dchk("s6_mode", int'(mode_out), 2);
        release dut.state_q;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dchk("s6_gnt_hold", int'(gnt), 0);
        end
        dchk("s6_idle_busy", int'(busy), 0);
        dchk("s6_idle_err",  int'(err), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // S5: lock while owned
        req_mode = {3'd0, 3'd0, 3'd3};
        req = 3'b001;
        wait_gnt(cyc);
        dchk("s5_lat",  cyc, 2);
        dchk("s5_mode", int'(mode_out), 3);
        lock = 1'b1;
        @(negedge clk);
        lock = 1'b0;
        dchk("s5_lock_gnt",  int'(gnt), 0);
        dchk("s5_lock_busy", int'(busy), 1);
        req = 3'b111; rel = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dchk("s5_frozen_gnt",  int'(gnt), 0);
            dchk("s5_frozen_mode", int'(mode_out), 3);
        end
        req = '0; rel = '0;
        rst = 1'b1;
        #1;
        dchk("s5_rst_gnt",  int'(gnt), 0);
        dchk("s5_rst_mode", int'(mode_out), 0);
        dchk("s5_rst_busy", int'(busy), 0);
        dchk("s5_rst_err",  int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
